// File: rtl/sc_frog_pkg.sv
// Shared types and codes for the frog movement controller and its helpers.
package sc_frog_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_MOVE = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  localparam logic [1:0] SHIFT_HOLD  = 2'b00;
  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;

  // Exactly one button pressed is a request; both or neither means hold.
  function automatic logic [1:0] decode_req(input logic l, input logic r);
    if (l && !r) return SHIFT_LEFT;
    if (r && !l) return SHIFT_RIGHT;
    return SHIFT_HOLD;
  endfunction

endpackage

// File: rtl/sc_frog_move_ctrl_btn_sync.sv
// Two-flop synchronizer for an active-low raw button, presented active-high.
module sc_btn_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_ni,
  output logic pressed_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[0], btn_ni};
    end
  end

  assign pressed_o = ~sync_q[1];

endmodule

// File: rtl/sc_frog_move_ctrl.sv
// Frog movement controller: button conditioning, auto-repeat, edge suppression
// and a saturating move counter driving the position shift register.
module sc_frog_move_ctrl
  import sc_frog_pkg::*;
#(
  parameter int unsigned           DATAWIDTH     = 8,
  parameter logic [DATAWIDTH-1:0]  START_POS     = 8'b00010000,
  parameter logic [DATAWIDTH-1:0]  MAX_POS       = 8'b10000000,
  parameter logic [DATAWIDTH-1:0]  MIN_POS       = 8'b00010000,
  parameter int unsigned           REPEAT_DELAY  = 24,
  parameter int unsigned           REPEAT_PERIOD = 8,
  parameter int unsigned           CNT_W         = 8
) (
  input  logic                 SC_FROGMOVECTRL_CLOCK_50,
  input  logic                 SC_FROGMOVECTRL_RESET_InLow,
  input  logic                 SC_FROGMOVECTRL_left_InLow,
  input  logic                 SC_FROGMOVECTRL_right_InLow,
  input  logic                 SC_FROGMOVECTRL_restart_InHigh,
  input  logic [DATAWIDTH-1:0] SC_FROGMOVECTRL_position_InBUS,
  output logic                 SC_FROGMOVECTRL_load_OutLow,
  output logic [1:0]           SC_FROGMOVECTRL_shiftselection_Out,
  output logic [DATAWIDTH-1:0] SC_FROGMOVECTRL_data_OutBUS,
  output logic [CNT_W-1:0]     SC_FROGMOVECTRL_movecount_OutBUS
);

  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;

  logic clk, rst_n;
  logic left, right;
  logic [1:0] req;
  logic       at_edge;

  state_e           state_q, state_d;
  logic [1:0]       dir_q, dir_d;
  logic             repeat_q, repeat_d;
  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             load_q, load_d;
  logic [1:0]       shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign clk   = SC_FROGMOVECTRL_CLOCK_50;
  assign rst_n = SC_FROGMOVECTRL_RESET_InLow;

  sc_btn_sync u_sync_left (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .btn_ni    (SC_FROGMOVECTRL_left_InLow),
    .pressed_o (left)
  );

  sc_btn_sync u_sync_right (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .btn_ni    (SC_FROGMOVECTRL_right_InLow),
    .pressed_o (right)
  );

  assign req     = decode_req(left, right);
  assign at_edge = (dir_q == SHIFT_LEFT) ? (SC_FROGMOVECTRL_position_InBUS == MAX_POS)
                                         : (SC_FROGMOVECTRL_position_InBUS == MIN_POS);

  // Output registers capture the action of the current state, so every load
  // and shift pulse is a single registered cycle with no glitches.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    repeat_d = repeat_q;
    rpt_d    = rpt_q;
    load_d   = 1'b1;
    shift_d  = SHIFT_HOLD;
    cnt_d    = cnt_q;

    unique case (state_q)
      ST_INIT: begin
        load_d  = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (SC_FROGMOVECTRL_restart_InHigh) begin
          state_d = ST_INIT;
        end else if (req != SHIFT_HOLD) begin
          dir_d    = req;
          repeat_d = 1'b0;
          state_d  = ST_MOVE;
        end
      end
      ST_MOVE: begin
        if (SC_FROGMOVECTRL_restart_InHigh) begin
          state_d = ST_INIT;
        end else begin
          if (!at_edge) begin
            shift_d = dir_q;
            cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          end
          rpt_d   = repeat_q ? RPT_W'(REPEAT_PERIOD - 1) : RPT_W'(REPEAT_DELAY - 1);
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (SC_FROGMOVECTRL_restart_InHigh) begin
          state_d = ST_INIT;
        end else if (req != dir_q) begin
          state_d = ST_IDLE;
        end else if (rpt_q == '0) begin
          repeat_d = 1'b1;
          state_d  = ST_MOVE;
        end else begin
          rpt_d = rpt_q - RPT_W'(1);
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_INIT;
      dir_q    <= SHIFT_LEFT;
      repeat_q <= 1'b0;
      rpt_q    <= '0;
      load_q   <= 1'b1;
      shift_q  <= SHIFT_HOLD;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      repeat_q <= repeat_d;
      rpt_q    <= rpt_d;
      load_q   <= load_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
    end
  end

  assign SC_FROGMOVECTRL_load_OutLow        = load_q;
  assign SC_FROGMOVECTRL_shiftselection_Out = shift_q;
  assign SC_FROGMOVECTRL_data_OutBUS        = START_POS;
  assign SC_FROGMOVECTRL_movecount_OutBUS   = cnt_q;

endmodule
